maxpool2x2_stream: RTL
======================

// Module: maxpool2x2_stream
// PURPOSE
//  Streaming 2x2 / stride-2 max-pooling stage between the conv layer output and the next layer.
//  - Consumes one feature map pixel per accepted beat, row-major, IMG_W x IMG_H.
//  - Emits one pooled pixel per 2x2 window, row-major, (IMG_W/2) x (IMG_H/2).
//  - Partial row maxima are held in a half-width line buffer, so a frame passes with no full-frame storage.
// PARAMETERS
//  DATA_W   16   pixel width; unsigned compare
//  IMG_W    24   input columns; must be even (sim-time assertion)
//  IMG_H    24   input rows; must be even (sim-time assertion)
// PORTS
//  clk       in   1        single clock, rising edge
//  rst_n     in   1        synchronous active-low reset
//  s_valid   in   1        input pixel valid
//  s_ready   out  1        input pixel accepted when s_valid && s_ready
//  s_data    in   DATA_W   input pixel
//  m_valid   out  1        pooled pixel valid
//  m_ready   in   1        downstream accept
//  m_data    out  DATA_W   pooled pixel = max of the 2x2 window
//  m_last    out  1        high with the final pooled pixel of a frame
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): m_valid=0, m_data=0, m_last=0, col=0, row=0, pair_reg=0.
//    s_ready is 1 out of reset. Line buffer is not cleared; even rows always overwrite it before odd rows read it.
//  Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on an input handshake.
//    col wraps to 0 and increments row. At row=IMG_H-1, col=IMG_W-1 both wrap to 0, starting the next frame.
//  Compare: max(a,b) = (a>b) ? a : b, unsigned DATA_W. Ties are value-equal, so either operand is correct.
//  Accept rules, per handshake:
//    even row, even col: pair_reg <= s_data
//    even row, odd col:  lbuf[col>>1] <= max(pair_reg, s_data)
//    odd row, even col:  pair_reg <= s_data
//    odd row, odd col:   m_data <= max(max(pair_reg, s_data), lbuf[col>>1]); m_valid <= 1.
//      m_last <= (row==IMG_H-1 && col==IMG_W-1).
//  Latency: m_valid rises the cycle after the handshake that completes the window.
//    Sustained throughput is 1 input pixel per cycle when m_ready=1.
//  Backpressure: s_ready = !m_valid || m_ready. This is a single output register.
//    While m_valid && !m_ready, no input is accepted (including non-emitting beats); m_data and m_last hold stable.
//  Output: m_valid clears on m_valid && m_ready unless a new window completes in the same cycle, in which case it stays 1 with the new data.
//  s_valid low: counters, pair_reg and lbuf hold. Gaps anywhere in a frame are legal.
//  Reset mid-frame: the partial frame is discarded, including any pending output (m_valid drops). The next accepted pixel is (row 0, col 0).
//  lbuf read: for odd-row odd-col, use the combinational/async read of the entry written in the previous even row.
//    There is no read/write collision, because rows alternate.
// STRUCTURE
//  Shared package cnn_pkg:
//    - DATA_W, MNIST conv map dims (24x24) and pooled dims (12x12).
//    - localparam function max_u(a,b).
//  Sub-module pool_line_buf: IMG_W/2 x DATA_W register array.
//    - One write port (we, waddr, wdata).
//    - One async read port (raddr -> rdata); no reset.
//  Top level holds the counters, pair_reg and the output register; no explicit FSM beyond the row/col parity.
// TESTING
//  1. IMG 4x4, m_ready=1, pixels 0..15 row-major
//     -> outputs 5,7,13,15 in order; m_last only on 15; each m_valid is 1 cycle after its 6th/8th/14th/16th accept.
//  2. Window {0xFFFF,0x0001 / 0x8000,0x7FFF}
//     -> 0xFFFF (unsigned, not signed). Window {3,3,3,3} -> 3.
//  3. m_ready=0 when the first output appears, held 5 cycles, s_valid=1 throughout
//     -> s_ready=0, m_data stable, counters frozen; resumes with no lost or duplicated pixels.
//  4. Random s_valid gaps plus random m_ready, two back-to-back 24x24 frames
//     -> 144 outputs per frame matching the reference model; m_last on the 144th and 288th outputs.
//  5. rst_n=0 for 1 cycle after 30 pixels of a 24x24 frame, then a fresh frame
//     -> m_valid=0 after reset; next frame's 144 outputs correct.
//  6. Output handshake in the same cycle a new window completes
//     -> m_valid stays 1, m_data updates to the new max, no bubble.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel width, MNIST conv/pool map dimensions and an unsigned max helper
//   DATA_W        pixel width used across the CNN datapath
//   MAP_W/MAP_H   conv layer output map (24x24)
//   POOL_W/POOL_H pooled map after 2x2 / stride-2 pooling (12x12)
//   max_u(a,b)    unsigned maximum; on a tie the operands are equal, so either is returned
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int MAP_W  = 24;
    localparam int MAP_H  = 24;
    localparam int POOL_W = MAP_W / 2;
    localparam int POOL_H = MAP_H / 2;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-width line buffer holding the row-pair maxima of the even row
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address (pooled column)
//   wdata  in   write data
//   raddr  in   read address (pooled column)
//   rdata  out  asynchronous read data
// The contents are never reset: every even row rewrites each entry before the odd row reads it.
module pool_line_buf #(
    parameter int DEPTH  = cnn_pkg::POOL_W,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 unsigned max-pooling of a row-major IMG_W x IMG_H frame
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   s_valid  in   input pixel valid
//   s_ready  out  input pixel accepted when s_valid && s_ready
//   s_data   in   input pixel
//   m_valid  out  pooled pixel valid
//   m_ready  in   downstream accept
//   m_data   out  pooled pixel, max of its 2x2 window
//   m_last   out  high with the final pooled pixel of a frame
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::MAP_W,
    parameter int IMG_H  = cnn_pkg::MAP_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_dim_check
        $error("maxpool2x2_stream: IMG_W and IMG_H must both be even");
    end

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] pair_reg;
    logic [DATA_W-1:0] lb_rdata;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] win_max;
    logic              acc;
    logic              col_end;
    logic              row_end;
    logic              lb_we;
    logic              emit;

    // One output register: input may only move when that register is free or draining this cycle.
    assign s_ready  = !m_valid || m_ready;
    assign acc      = s_valid && s_ready;
    assign col_end  = col == CW'(IMG_W - 1);
    assign row_end  = row == RW'(IMG_H - 1);
    assign pair_max = max_u(pair_reg, s_data);
    assign win_max  = max_u(pair_max, lb_rdata);
    // Odd columns close a horizontal pair: even rows park it, odd rows finish the window.
    assign lb_we    = acc && !row[0] && col[0];
    assign emit     = acc && row[0] && col[0];

    pool_line_buf #(
        .DEPTH (IMG_W / 2),
        .DATA_W(DATA_W),
        .AW    (CW - 1)
    ) u_lbuf (
        .clk  (clk),
        .we   (lb_we),
        .waddr(col[CW-1:1]),
        .wdata(pair_max),
        .raddr(col[CW-1:1]),
        .rdata(lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            pair_reg <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
        end else begin
            if (acc) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
                if (!col[0])
                    pair_reg <= s_data;
            end
            // A completing window overrides the drain so back-to-back outputs carry no bubble.
            if (emit) begin
                m_valid <= 1'b1;
                m_data  <= win_max;
                m_last  <= row_end && col_end;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
